imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream (e.g. from a UART receiver) and writes it word by word into the instruction memory write port.
- Holds the CPU in reset while a load is in progress, then releases it.
- Sits between the byte source and the instruction memory; the CPU fetch path remains the reader.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be 32 (4 bytes per word).
- ADDRESS_WIDTH, 32, width of the byte address driven to memory.
- MEM_SIZE, 256, memory depth in words; maximum accepted program length.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts the byte this cycle; a transfer happens when byte_valid and byte_ready are both high.
- we  output  1  instruction memory write enable, one cycle per word.
- wr_address  output  ADDRESS_WIDTH  byte address, word aligned (bits [1:0] = 0); the word index is carried in bits [9:2].
- wr_data  output  DATA_WIDTH  assembled instruction word.
- busy  output  1  load in progress.
- cpu_hold  output  1  hold the CPU in reset; equals busy.
- done  output  1  high from load completion until the next start or rst.
- error  output  1  high from error detection until the next start or rst.
- word_count  output  9  number of words written in the current or last load.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters and the shift register cleared.
- Reset mid-load: returns to IDLE the next cycle with we = 0. Words already written stay in memory; nothing is cleared.
- Stream format:
  - Byte 0 is the word count N, low byte; byte 1 is N, high byte.
  - These are followed by 4*N payload bytes, little-endian per word: the first byte goes to wr_data[7:0].
- States:
  - IDLE: byte_ready = 0. On start, go to LEN_LO and set busy = 1. done, error and word_count clear on the same edge.
  - LEN_LO: byte_ready = 1. The accepted byte becomes N[7:0]; go to LEN_HI.
  - LEN_HI: byte_ready = 1. The accepted byte becomes N[15:8]. If N == 0 or N > MEM_SIZE, go to ERROR; otherwise go to PAYLOAD.
  - PAYLOAD: byte_ready = 1. Each accepted byte shifts into the word register and increments the byte counter (0..3). On the 4th byte, go to WRITE.
  - WRITE: byte_ready = 0 and we = 1 for exactly one cycle, with wr_address = word_count*4 and wr_data = assembled word. word_count increments on the same edge. If word_count+1 == N, go to DONE (or CHECK when the optional feature is enabled); otherwise return to PAYLOAD.
  - DONE: busy = 0, cpu_hold = 0, done = 1, byte_ready = 0.
  - ERROR: busy = 0, cpu_hold = 0, error = 1, byte_ready = 0. No further writes occur.
- Latency: we asserts in the cycle after the 4th byte of a word is accepted.
- Back-to-back bytes are accepted every cycle except during WRITE, so the sustained rate is 4 bytes per 5 cycles.
- byte_valid while byte_ready = 0: the byte is not consumed and the source must hold it.
- start while busy is ignored.
- Bytes arriving in IDLE, DONE or ERROR are never accepted.
- wr_address is 0 whenever we = 0.
- The word index never exceeds MEM_SIZE-1, because N is range-checked before any write.

Optional Feature:
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last WRITE, enter CHECK with byte_ready = 1.
  - The accepted byte is compared against the XOR of all 4*N payload bytes.
  - Match goes to DONE; mismatch goes to ERROR.
  - Memory has already been written in either case.
- Macro not defined: CHECK does not exist, the stream ends after the last payload byte, and WRITE goes straight to DONE.

Decomposition:
- Package imem_loader_pkg:
  - state enum: IDLE, LEN_LO, LEN_HI, PAYLOAD, WRITE, CHECK, DONE, ERROR.
  - BYTES_PER_WORD = 4.
  - COUNT_WIDTH = 9.
- Sub-module byte_packer: 4-byte little-endian shift/assemble register with a byte counter and a word_full flag, cleared by rst and by start.

Test Plan:
- Normal load: start, then bytes 02 00 13 00 00 00 93 00 10 00 (two words). Expect two writes: we at addr 0x0 with data 0x00000013, then addr 0x4 with 0x00100093. Then done = 1, word_count = 2, cpu_hold falls.
- Length errors: N = 0 (00 00) gives error = 1 with no we. N = 257 (01 01) with MEM_SIZE = 256 gives error = 1 with no we.
- Full memory: N = 256 with an incrementing pattern. Expect the last write at addr 0x3FC, word_count = 256, done = 1.
- Backpressure and gaps: byte_valid held high continuously must show byte_ready = 0 in every WRITE cycle with no byte lost. Randomly idle byte_valid cycles must produce identical memory contents.
- Reset and restart: assert rst after 6 payload bytes. Expect IDLE next cycle, we = 0, busy = 0. A new start with N = 1 then writes addr 0x0 correctly.
- Checksum (IMEM_LOADER_CHECKSUM_EN only): N = 1, payload 11 22 33 44, check byte 0x44 gives done. Check byte 0x00 gives error after the write.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared state encoding and sizing constants for the instruction memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_WIDTH    = 9;
  localparam int LEN_WIDTH      = 16;
  localparam int BYTE_IDX_WIDTH = 2;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: the first byte shifted in ends up in bits [7:0].
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          shift_i,
  input  logic                          consume_i,
  input  logic [7:0]                    byte_i,
  output logic [8*BYTES_PER_WORD-1:0]   word_o,
  output logic [BYTE_IDX_WIDTH-1:0]     count_o,
  output logic                          word_full_o
);

  logic [8*BYTES_PER_WORD-1:0] word_q, word_d;
  logic [BYTE_IDX_WIDTH-1:0]   count_q, count_d;
  logic                        full_q, full_d;

  // New bytes enter at the top so that after four shifts the oldest sits at the bottom.
  always_comb begin
    word_d  = word_q;
    count_d = count_q;
    full_d  = full_q;
    if (clear_i) begin
      word_d  = '0;
      count_d = '0;
      full_d  = 1'b0;
    end else if (shift_i) begin
      word_d  = {byte_i, word_q[8*BYTES_PER_WORD-1:8]};
      count_d = count_q + 1'b1;
      full_d  = (count_q == BYTE_IDX_WIDTH'(BYTES_PER_WORD - 1));
    end else if (consume_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  assign word_o      = word_q;
  assign count_o     = count_q;
  assign word_full_o = full_q;

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into instruction memory while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_SIZE      = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     we,
  output logic [ADDRESS_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     busy,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error,
  output logic [COUNT_WIDTH-1:0]   word_count
);

  state_e                      state_q, state_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic [COUNT_WIDTH-1:0]      count_q, count_d;
  logic [LEN_WIDTH-1:0]        len_full;
  logic                        quiescent;
  logic                        start_ok;
  logic                        last_word;
  logic                        pack_shift;
  logic                        word_full;
  logic [8*BYTES_PER_WORD-1:0] pack_word;
  logic [BYTE_IDX_WIDTH-1:0]   pack_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]                  csum_q, csum_d;
`endif

  assign quiescent  = (state_q == IDLE) || (state_q == DONE) || (state_q == ERROR);
  assign start_ok   = start & quiescent;
  assign len_full   = {byte_data, len_q[7:0]};
  assign last_word  = ((LEN_WIDTH'(count_q) + 16'd1) == len_q);
  assign pack_shift = byte_valid & byte_ready & (state_q == PAYLOAD);

  byte_packer u_packer (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (start_ok),
    .shift_i     (pack_shift),
    .consume_i   (we),
    .byte_i      (byte_data),
    .word_o      (pack_word),
    .count_o     (pack_count),
    .word_full_o (word_full)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    byte_ready = 1'b0;
    we         = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LEN_LO;
          len_d   = '0;
          count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          len_d[7:0] = byte_data;
          state_d    = LEN_HI;
        end
      end
      // The length is range-checked here so no write can ever land beyond the memory.
      LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          len_d   = len_full;
          state_d = ((len_full == '0) || (len_full > LEN_WIDTH'(MEM_SIZE))) ? ERROR : PAYLOAD;
        end
      end
      PAYLOAD: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ byte_data;
`endif
          if (pack_count == BYTE_IDX_WIDTH'(BYTES_PER_WORD - 1)) state_d = WRITE;
        end
      end
      WRITE: begin
        we      = word_full;
        count_d = count_q + 9'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_d = last_word ? CHECK : PAYLOAD;
`else
        state_d = last_word ? DONE : PAYLOAD;
`endif
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        byte_ready = 1'b1;
        if (byte_valid) state_d = (byte_data == csum_q) ? DONE : ERROR;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign wr_address = we ? ADDRESS_WIDTH'({count_q, 2'b00}) : '0;
  assign wr_data    = we ? DATA_WIDTH'(pack_word) : '0;
  assign busy       = ~quiescent;
  assign cpu_hold   = ~quiescent;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERROR);
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized program loads into imem_loader, checked against a stream-level model.
// Honours IMEM_LOADER_CHECKSUM_EN by appending the XOR byte and running the checksum cases.
module tb_imem_loader;

  localparam int MEM_SIZE = 256;
  localparam int STREAM_BUDGET = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] wr_address;
  logic [31:0] wr_data;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [8:0]  word_count;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  stim[$];
  logic [31:0] obsAddr[$];
  logic [31:0] obsData[$];
  int          bpViol;
  int          addrViol;
  int          latViol;
  logic        prevWordEnd;

  imem_loader #(
    .DATA_WIDTH    (32),
    .ADDRESS_WIDTH (32),
    .MEM_SIZE      (MEM_SIZE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before the test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called once per cycle at the falling edge: records writes and protocol violations.
  task automatic observeCycle();
    if (we) begin
      obsAddr.push_back(wr_address);
      obsData.push_back(wr_data);
      if (byte_ready) bpViol++;
      if (!prevWordEnd) latViol++;
    end else begin
      if (wr_address != 32'd0) addrViol++;
      if (prevWordEnd) latViol++;
    end
    prevWordEnd = 1'b0;
  endtask

  task automatic buildStream(input int n, input bit randomPayload);
    stim.delete();
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) stim.push_back(randomPayload ? 8'($urandom) : 8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
    appendChecksum();
`endif
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic appendChecksum();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < stim.size(); i++) x ^= stim[i];
    stim.push_back(x);
  endtask
`endif

  task automatic pulseStart();
    @(negedge clk);
    observeCycle();
    start = 1'b1;
    @(negedge clk);
    observeCycle();
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("count_after_start", 32'(word_count), 32'd0);
    checkOutput("flags_after_start", 32'(done | error), 32'd0);
  endtask

  // Offers stim[0..maxBytes-1] as a valid/ready stream, optionally with idle gaps and stray starts.
  task automatic applyStimulus(input int gapPct, input bit startNoise, input int maxBytes);
    int idx = 0;
    int cycles = 0;
    int limit;
    limit = (maxBytes < stim.size()) ? maxBytes : stim.size();
    while (idx < limit && cycles < STREAM_BUDGET) begin
      @(negedge clk);
      observeCycle();
      byte_valid = (int'($urandom_range(99)) >= gapPct);
      byte_data  = byte_valid ? stim[idx] : 8'($urandom);
      start      = startNoise ? 1'($urandom) : 1'b0;
      if (byte_valid && byte_ready) begin
        prevWordEnd = (idx >= 2) && (((idx - 2) % 4) == 3);
        idx++;
      end
      cycles++;
    end
    @(negedge clk);
    observeCycle();
    byte_valid = 1'b0;
    start      = 1'b0;
    checkOutput("bytes_accepted", 32'(idx), 32'(limit));
    if (limit == stim.size()) begin
      repeat (4) begin
        @(negedge clk);
        observeCycle();
      end
    end
  endtask

  task automatic runLoad(input string tag, input int gapPct, input bit startNoise);
    int n;
    int nWrites;
    bit lenOk;
    bit expectDone;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
`endif
    obsAddr.delete();
    obsData.delete();
    bpViol = 0;
    addrViol = 0;
    latViol = 0;
    prevWordEnd = 1'b0;
    pulseStart();
    applyStimulus(gapPct, startNoise, stim.size());

    n          = int'(stim[0]) + 256 * int'(stim[1]);
    lenOk      = (n >= 1) && (n <= MEM_SIZE);
    nWrites    = lenOk ? n : 0;
    expectDone = lenOk;
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = 2; i < 2 + 4 * nWrites; i++) x ^= stim[i];
    if (lenOk) expectDone = (stim[2 + 4 * n] == x);
`endif

    checkOutput({tag, "_writes"}, 32'(obsAddr.size()), 32'(nWrites));
    for (int k = 0; k < nWrites && k < obsAddr.size(); k++) begin
      int b = 2 + 4 * k;
      checkOutput($sformatf("%s_addr%0d", tag, k), obsAddr[k], 32'(4 * k));
      checkOutput($sformatf("%s_data%0d", tag, k), obsData[k], {stim[b+3], stim[b+2], stim[b+1], stim[b]});
    end
    checkOutput({tag, "_done"}, 32'(done), 32'(expectDone));
    checkOutput({tag, "_error"}, 32'(error), 32'(!expectDone));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    checkOutput({tag, "_ready_after"}, 32'(byte_ready), 32'd0);
    checkOutput({tag, "_word_count"}, 32'(word_count), 32'(nWrites));
    checkOutput({tag, "_ready_in_write"}, 32'(bpViol), 32'd0);
    checkOutput({tag, "_addr_when_idle"}, 32'(addrViol), 32'd0);
    checkOutput({tag, "_write_latency"}, 32'(latViol), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    prevWordEnd = 1'b0;
    bpViol      = 0;
    addrViol    = 0;
    latViol     = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_we", 32'(we), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    checkOutput("reset_ready", 32'(byte_ready), 32'd0);
    checkOutput("reset_word_count", 32'(word_count), 32'd0);
    checkOutput("reset_wr_address", wr_address, 32'd0);
    checkOutput("reset_wr_data", wr_data, 32'd0);
    rst = 1'b0;

    $display("[TB] two-word directed load");
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    appendChecksum();
`endif
    runLoad("normal", 0, 1'b0);
    checkOutput("normal_word0_const", (obsData.size() > 0) ? obsData[0] : 32'hDEADBEEF, 32'h00000013);
    checkOutput("normal_word1_const", (obsData.size() > 1) ? obsData[1] : 32'hDEADBEEF, 32'h00100093);
    checkOutput("normal_addr1_const", (obsAddr.size() > 1) ? obsAddr[1] : 32'hDEADBEEF, 32'h00000004);

    $display("[TB] length errors");
    stim = '{8'h00, 8'h00};
    runLoad("len_zero", 0, 1'b0);
    stim = '{8'h01, 8'h01};
    runLoad("len_257", 0, 1'b0);

    $display("[TB] full memory load");
    buildStream(MEM_SIZE, 1'b0);
    runLoad("full", 0, 1'b0);
    checkOutput("full_last_addr", (obsAddr.size() > 0) ? obsAddr[obsAddr.size() - 1] : 32'hDEADBEEF, 32'h000003FC);

    $display("[TB] randomized loads with backpressure and gaps");
    buildStream(int'($urandom_range(24, 1)), 1'b1);
    runLoad("rand_hold", 0, 1'b1);
    runLoad("rand_gaps", 50, 1'b0);
    for (int r = 0; r < 3; r++) begin
      buildStream(int'($urandom_range(16, 1)), 1'b1);
      runLoad($sformatf("rand_mix%0d", r), 35, 1'b1);
    end

    $display("[TB] reset mid-load and restart");
    buildStream(3, 1'b1);
    obsAddr.delete();
    obsData.delete();
    prevWordEnd = 1'b0;
    pulseStart();
    applyStimulus(0, 1'b0, 8);
    rst = 1'b1;
    @(negedge clk);
    observeCycle();
    checkOutput("rst_mid_we", 32'(we), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("rst_mid_ready", 32'(byte_ready), 32'd0);
    checkOutput("rst_mid_flags", 32'(done | error), 32'd0);
    checkOutput("rst_mid_word_count", 32'(word_count), 32'd0);
    rst = 1'b0;
    checkOutput("rst_mid_writes", 32'(obsAddr.size()), 32'd1);
    checkOutput("rst_mid_word0", (obsData.size() > 0) ? obsData[0] : 32'hDEADBEEF,
                {stim[5], stim[4], stim[3], stim[2]});
    buildStream(1, 1'b1);
    runLoad("restart", 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum cases");
    stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    runLoad("csum_ok", 0, 1'b0);
    checkOutput("csum_ok_done_const", 32'(done), 32'd1);
    stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    runLoad("csum_bad", 0, 1'b0);
    checkOutput("csum_bad_error_const", 32'(error), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
